input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
Conditions 8 raw asynchronous switch/button inputs into a clean, glitch-free data vector for the downstream combinational 8-bit priority encoder / 7-segment decoder stage. Each bit is synchronised, then debounced by requiring a stable new level for a programmable number of clocks. The block provides an optional output hold and a one-cycle change strobe.

Parameters:
WIDTH, 8, number of input bits (downstream encoder expects 8)
SYNC_STAGES, 2, flip-flops in each bit's synchroniser chain (>=2)
DEBOUNCE_CYCLES, 50000, consecutive clocks a new level must persist before acceptance (>=1); 1 ms at 50 MHz
CNT_W, 16, debounce counter width; DEBOUNCE_CYCLES-1 must fit in CNT_W bits

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
raw_in  input  WIDTH  asynchronous raw switch levels
hold  input  1  1 = freeze data output; debouncing continues internally
data  output  WIDTH  debounced vector, feeds encoder data[7:0]
changed  output  1  one-cycle pulse, asserted in the same cycle a new value appears on data

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst. When rst=1 at a rising edge, all synchroniser flops, per-bit stable state, counters, data and changed clear to 0. Reset mid-debounce discards any partial count. raw_in is ignored while rst=1.
- Synchroniser: per-bit chain of SYNC_STAGES flops. sync_bit is the last stage. No logic between stages.
- Per-bit debounce, evaluated each edge:
  - sync_bit == stable: cnt <= 0.
  - sync_bit != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync_bit, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A single-cycle return to the old level restarts the count from 0 (no accumulation across glitches).
- Latency: raw bit changes and is steady from edge 0 (sampled at edge 0). stable flips at edge SYNC_STAGES+DEBOUNCE_CYCLES-1. data updates at that same edge when hold=0. Example: S=2, D=4 gives edge 5.
- DEBOUNCE_CYCLES=1: stable follows sync_bit with no extra delay.
- Bits are fully independent. Simultaneous changes on several bits that settle on the same edge appear together in one data update with one changed pulse.
- Output register:
  - hold=0: data <= next stable vector. changed <= (next stable vector != data).
  - hold=1: data keeps its value, changed <= 0.
  - Falling edge of hold: the first edge with hold=0 loads the current stable vector. changed pulses only if that vector differs from the held value.
- changed is never high for two consecutive cycles unless data differs on each of those edges.
- Outputs are purely registered. There are no combinational paths from raw_in or hold to any output.

Decomposition:
- Shared package holds:
  - DEFAULT_WIDTH = 8
  - DEFAULT_SYNC_STAGES = 2
  - DEFAULT_DEBOUNCE_CYCLES = 50000
  - DEFAULT_CNT_W = 16
  - a simulation constant SIM_DEBOUNCE_CYCLES = 4
- One sub-module, debounce_bit (synchroniser chain + counter + stable flop; parameters SYNC_STAGES, DEBOUNCE_CYCLES, CNT_W), instantiated WIDTH times via generate.
- The top level adds the hold/output register and the changed compare.

Test Plan:
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
1. Reset with raw_in=8'hFF held high during rst=1 -> data=8'h00, changed=0 throughout reset and on the first edge after release.
2. raw_in 8'h00->8'h80 steady, applied before edge 0 -> data=8'h80 exactly at edge 5, changed=1 for that one cycle only, 0 afterwards.
3. Bit 3 bounces 1,0,1,0,1 (one cycle each), then stays 1 -> no change during the bounce. data=8'h08 exactly 4 clocks after the sync output last settled high. Exactly one changed pulse.
4. hold=1, then raw_in 8'h00->8'h24 steady for 20 cycles -> data stays 8'h00, changed=0. Drop hold -> next edge data=8'h24, changed=1 for one cycle.
5. hold=1 while raw_in goes 8'h00->8'h01->8'h00, each level steady for 10 cycles. Release hold -> data stays 8'h00, no changed pulse.
6. raw_in steady at 8'h40 for 3 clocks past sync (cnt=2), then rst=1 for one edge, then rst=0 -> data=8'h00, and the full count restarts: data=8'h40 at edge 5 after release.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Shared defaults for the input debouncer: production parameter values
// and the short debounce length used in simulation.
package input_debouncer_pkg;

    localparam int DEFAULT_WIDTH           = 8;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_CNT_W           = 16;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;

endpackage : input_debouncer_pkg

// File: rtl/input_debouncer_if.sv
// Switch-conditioning bus: raw levels and hold in, debounced vector and change strobe out.
interface input_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] raw_in;
    logic             hold;
    logic [WIDTH-1:0] data;
    logic             changed;

    modport master (
        output raw_in,
        output hold,
        input  data,
        input  changed
    );

    modport slave (
        input  raw_in,
        input  hold,
        output data,
        output changed
    );
endinterface : input_debouncer_if

// File: rtl/input_debouncer_debounce_bit.sv
// One input bit: synchroniser chain followed by a stability counter.
// Exposes the stable level it will hold after the coming edge.
module debounce_bit
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable_nxt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stable;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_sync_bit;
    logic                   w_stable_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;

    assign w_sync_bit   = r_sync[SYNC_STAGES-1];
    assign o_stable_nxt = w_stable_nxt;

    // Any return to the stable level clears the count, so glitches never accumulate.
    always_comb begin
        w_stable_nxt = r_stable;
        w_cnt_nxt    = r_cnt;
        if (w_sync_bit == r_stable) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else if (r_cnt == LAST_CNT) begin
            w_stable_nxt = w_sync_bit;
            w_cnt_nxt    = {CNT_W{1'b0}};
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Synchroniser, counter and stable level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= {SYNC_STAGES{1'b0}};
            r_stable <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_stable <= w_stable_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

endmodule : debounce_bit

// File: rtl/input_debouncer.sv
// Debounces WIDTH raw switch inputs and presents them through a holdable
// output register with a one-cycle change strobe.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input logic               clk,
    input logic               rst,
    input_debouncer_if.slave  bus
);

    logic [WIDTH-1:0] w_stable_nxt;
    logic [WIDTH-1:0] r_data;
    logic             r_changed;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk          (clk),
            .rst          (rst),
            .i_raw        (bus.raw_in[g]),
            .o_stable_nxt (w_stable_nxt[g])
        );
    end

    // Output register loads the freshly settled vector so data moves on the same edge as the stable flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= {WIDTH{1'b0}};
            r_changed <= 1'b0;
        end else if (bus.hold) begin
            r_data    <= r_data;
            r_changed <= 1'b0;
        end else begin
            r_data    <= w_stable_nxt;
            r_changed <= (w_stable_nxt != r_data);
        end
    end

    assign bus.data    = r_data;
    assign bus.changed = r_changed;

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// Scenario bench for input_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4;
// expected per-edge outputs are queued with the stimulus and compared as the edges occur.
module tb_input_debouncer;
    import input_debouncer_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       changed;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    input_debouncer_if #(.WIDTH(8)) bus ();

    input_debouncer #(
        .WIDTH           (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES),
        .CNT_W           (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input int n, input logic [7:0] d, input logic c);
        exp_t x;
        x.data    = d;
        x.changed = c;
        for (int i = 0; i < n; i++) q.push_back(x);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.raw_in = 8'hFF;
        bus.hold   = 1'b0;
        push_exp(3, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            e = q.pop_front(); checks++;
            if (bus.data !== e.data || bus.changed !== e.changed) begin
                errors++;
                $display("FAIL reset_hold edge %0d: data=%h changed=%b expected data=%h changed=%b", i, bus.data, bus.changed, e.data, e.changed);
            end
        end
        rst = 1'b0;
        push_exp(1, 8'h00, 1'b0);
        @(posedge clk); #1;
        e = q.pop_front(); checks++;
        if (bus.data !== e.data || bus.changed !== e.changed) begin
            errors++;
            $display("FAIL reset_release data=%h changed=%b expected data=%h changed=%b", bus.data, bus.changed, e.data, e.changed);
        end
        // The FF seen right after release lasts only one cycle, far short of the debounce length.
        bus.raw_in = 8'h00;
        push_exp(10, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            e = q.pop_front(); checks++;
            if (bus.data !== e.data || bus.changed !== e.changed) begin
                errors++;
                $display("FAIL reset_settle edge %0d: data=%h changed=%b expected data=%h changed=%b", i, bus.data, bus.changed, e.data, e.changed);
            end
        end
    endtask

    task automatic test_latency();
        bus.raw_in = 8'h80;
        push_exp(5, 8'h00, 1'b0);
        push_exp(1, 8'h80, 1'b1);
        push_exp(4, 8'h80, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            e = q.pop_front(); checks++;
            if (bus.data !== e.data || bus.changed !== e.changed) begin
                errors++;
                $display("FAIL latency edge %0d: data=%h changed=%b expected data=%h changed=%b", i, bus.data, bus.changed, e.data, e.changed);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pattern [0:4];
        pattern[0] = 8'h08; pattern[1] = 8'h00; pattern[2] = 8'h08;
        pattern[3] = 8'h00; pattern[4] = 8'h08;
        rst = 1'b1;
        bus.raw_in = 8'h00;
        push_exp(1, 8'h00, 1'b0);
        @(posedge clk); #1;
        e = q.pop_front(); checks++;
        if (bus.data !== e.data || bus.changed !== e.changed) begin
            errors++;
            $display("FAIL bounce_reset data=%h changed=%b expected data=%h changed=%b", bus.data, bus.changed, e.data, e.changed);
        end
        rst = 1'b0;
        // Level is steady from edge 4, so it is accepted at edge 4+5.
        push_exp(9, 8'h00, 1'b0);
        push_exp(1, 8'h08, 1'b1);
        push_exp(4, 8'h08, 1'b0);
        for (int i = 0; i < 14; i++) begin
            bus.raw_in = (i < 5) ? pattern[i] : 8'h08;
            @(posedge clk); #1;
            e = q.pop_front(); checks++;
            if (bus.data !== e.data || bus.changed !== e.changed) begin
                errors++;
                $display("FAIL bounce edge %0d: data=%h changed=%b expected data=%h changed=%b", i, bus.data, bus.changed, e.data, e.changed);
            end
        end
    endtask

    task automatic test_hold_release();
        rst = 1'b1;
        bus.raw_in = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.hold   = 1'b1;
        bus.raw_in = 8'h24;
        push_exp(20, 8'h00, 1'b0);
        push_exp(1, 8'h24, 1'b1);
        push_exp(3, 8'h24, 1'b0);
        for (int i = 0; i < 24; i++) begin
            if (i == 20) bus.hold = 1'b0;
            @(posedge clk); #1;
            e = q.pop_front(); checks++;
            if (bus.data !== e.data || bus.changed !== e.changed) begin
                errors++;
                $display("FAIL hold_release edge %0d: data=%h changed=%b expected data=%h changed=%b", i, bus.data, bus.changed, e.data, e.changed);
            end
        end
    endtask

    task automatic test_hold_no_change();
        rst = 1'b1;
        bus.raw_in = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.hold = 1'b1;
        push_exp(25, 8'h00, 1'b0);
        for (int i = 0; i < 25; i++) begin
            bus.raw_in = (i >= 10) ? 8'h00 : 8'h01;
            if (i == 20) bus.hold = 1'b0;
            @(posedge clk); #1;
            e = q.pop_front(); checks++;
            if (bus.data !== e.data || bus.changed !== e.changed) begin
                errors++;
                $display("FAIL hold_no_change edge %0d: data=%h changed=%b expected data=%h changed=%b", i, bus.data, bus.changed, e.data, e.changed);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        rst = 1'b1;
        bus.raw_in = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.raw_in = 8'h40;
        push_exp(5, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) rst = 1'b1;
            @(posedge clk); #1;
            e = q.pop_front(); checks++;
            if (bus.data !== e.data || bus.changed !== e.changed) begin
                errors++;
                $display("FAIL mid_reset edge %0d: data=%h changed=%b expected data=%h changed=%b", i, bus.data, bus.changed, e.data, e.changed);
            end
        end
        rst = 1'b0;
        push_exp(5, 8'h00, 1'b0);
        push_exp(1, 8'h40, 1'b1);
        push_exp(3, 8'h40, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            e = q.pop_front(); checks++;
            if (bus.data !== e.data || bus.changed !== e.changed) begin
                errors++;
                $display("FAIL restart edge %0d: data=%h changed=%b expected data=%h changed=%b", i, bus.data, bus.changed, e.data, e.changed);
            end
        end
    endtask

    initial begin
        bus.raw_in = 8'hFF;
        bus.hold   = 1'b0;
        #1;
        test_reset();
        test_latency();
        test_bounce();
        test_hold_release();
        test_hold_no_change();
        test_reset_mid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_input_debouncer
